// File: rtl/generic_clkdiv_pkg.sv
// Shared types and constants for the generic_clkdiv divider bank.
package generic_clkdiv_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,
        RUN    = 2'd1,
        RELOAD = 2'd2
    } ch_state_e;

    localparam int unsigned DIV_MIN = 2;

endpackage

// File: rtl/generic_clkdiv_ch.sv
// One divider channel: period counter, divisor reload and registered outputs.
// GENERIC_CLKDIV_SYNC_EN enables the sync realignment input.
module generic_clkdiv_ch
    import generic_clkdiv_pkg::*;
#(
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DEF_DIV = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             clk_ce,
    output logic             locked
);

    localparam int unsigned HW = DIV_W + 1;

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             term;
    logic             run_d;
    logic [HW-1:0]    half_d;

    assign term = (cnt_q == div_q - DIV_W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        pend_d  = pend_q;
        case (state_q)
            HOLD: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                cnt_d = term ? '0 : cnt_q + DIV_W'(1);
                // A wrap in the accept cycle still uses the old divisor.
                if (load) begin
                    state_d = RELOAD;
                    pend_d  = load_div;
                end
            end
            RELOAD: begin
                if (term) begin
                    cnt_d   = '0;
                    div_d   = pend_q;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: state_d = HOLD;
        endcase
`ifdef GENERIC_CLKDIV_SYNC_EN
        if (sync && (state_q != HOLD)) begin
            cnt_d = '0;
            if (state_q == RELOAD) begin
                div_d = pend_q;
            end
        end
`endif
    end

`ifndef GENERIC_CLKDIV_SYNC_EN
    logic sync_unused;
    assign sync_unused = sync;
`endif

    assign half_d = ({1'b0, div_d} + HW'(1)) >> 1;
    assign run_d  = (state_d != HOLD);

    // Outputs are registered from next-state so they line up with cnt_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            div_q   <= DIV_W'(DEF_DIV);
            pend_q  <= '0;
            clk_out <= 1'b0;
            clk_ce  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            clk_out <= run_d && ({1'b0, cnt_d} < half_d);
            clk_ce  <= run_d && (cnt_d == div_d - DIV_W'(1));
        end
    end

    assign locked = (state_q == RUN);

endmodule

// File: rtl/generic_clkdiv.sv
// Multi-channel clock divider with warm-up lock and divisor reload handshake.
// GENERIC_CLKDIV_SYNC_EN enables sync_in realignment of all channels.
module generic_clkdiv
    import generic_clkdiv_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned DEF_DIV     = 2,
    parameter int unsigned LOCK_CYCLES = 8,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sync_in,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] clk_ce,
    output logic [NUM_CH-1:0] locked,
    output logic              all_locked
);

    localparam int unsigned WU_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

    logic [WU_W-1:0]   wcnt_q;
    logic              start;
    logic              hs;
    logic              bad;
    logic [NUM_CH-1:0] load;

    // Saturates at LOCK_CYCLES so start fires exactly once per reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wcnt_q <= '0;
        end else if (32'(wcnt_q) < LOCK_CYCLES) begin
            wcnt_q <= wcnt_q + WU_W'(1);
        end
    end

    assign start = (32'(wcnt_q) == LOCK_CYCLES - 1);

    assign hs  = cfg_valid && cfg_ready;
    assign bad = (32'(cfg_div) < DIV_MIN) || (32'(cfg_ch) >= NUM_CH);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= hs && bad;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load[i] = hs && !bad && (32'(cfg_ch) == i);

        generic_clkdiv_ch #(
            .DIV_W   (DIV_W),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk_in),
            .rst      (rst_in),
            .start    (start),
            .load     (load[i]),
            .load_div (cfg_div),
            .sync     (sync_in),
            .clk_out  (clk_out[i]),
            .clk_ce   (clk_ce[i]),
            .locked   (locked[i])
        );
    end

    assign all_locked = &locked;
    assign cfg_ready  = &locked;

endmodule

// File: tb/tb_generic_clkdiv.sv
// Self-checking bench for generic_clkdiv: time-based period/phase model plus directed vectors.
module tb_generic_clkdiv;

    localparam int NCH  = 4;
    localparam int LOCK = 8;
    localparam int DEFD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [7:0] cfg_div = '0;
    logic       sync_in = 1'b0;
    logic       cfg_ready, cfg_err, all_locked;
    logic [3:0] clk_out, clk_ce, locked;

    // Second instance with NUM_CH=3 so an out-of-range channel number is encodable.
    logic       cfg_valid3 = 1'b0;
    logic [1:0] cfg_ch3 = '0;
    logic [7:0] cfg_div3 = '0;
    logic       cfg_ready3, cfg_err3, all_locked3;
    logic [2:0] clk_out3, clk_ce3, locked3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    generic_clkdiv dut (
        .clk_in     (clk),
        .rst_in     (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .cfg_err    (cfg_err),
        .sync_in    (sync_in),
        .clk_out    (clk_out),
        .clk_ce     (clk_ce),
        .locked     (locked),
        .all_locked (all_locked)
    );

    generic_clkdiv #(.NUM_CH(3)) dut3 (
        .clk_in     (clk),
        .rst_in     (rst),
        .cfg_valid  (cfg_valid3),
        .cfg_ready  (cfg_ready3),
        .cfg_ch     (cfg_ch3),
        .cfg_div    (cfg_div3),
        .cfg_err    (cfg_err3),
        .sync_in    (1'b0),
        .clk_out    (clk_out3),
        .clk_ce     (clk_ce3),
        .locked     (locked3),
        .all_locked (all_locked3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each running channel is a period D started at edge t0; phase = (cyc - t0) mod D.
    int cyc = 0;
    int m_st[NCH];   // 0 hold, 1 run, 2 reload
    int m_t0[NCH];
    int m_div[NCH];
    int m_pend[NCH];
    bit m_err = 0;

    task automatic model_step();
        bit rdy, bad, was_run;
        int cprev;
        rdy = 1;
        for (int c = 0; c < NCH; c++) if (m_st[c] != 1) rdy = 0;
        if (rst) begin
            cyc   = 0;
            m_err = 0;
            for (int c = 0; c < NCH; c++) begin
                m_st[c] = 0; m_t0[c] = 0; m_div[c] = DEFD; m_pend[c] = 0;
            end
        end else begin
            cyc++;
            bad   = (cfg_div < 2) || (int'(cfg_ch) >= NCH);
            m_err = cfg_valid && rdy && bad;
            for (int c = 0; c < NCH; c++) begin
                if (m_st[c] == 0) begin
                    if (cyc == LOCK) begin m_st[c] = 1; m_t0[c] = cyc; end
                end else begin
                    was_run = (m_st[c] == 1);
                    cprev   = (cyc - 1 - m_t0[c]) % m_div[c];
                    if (m_st[c] == 2 && cprev == m_div[c] - 1) begin
                        m_div[c] = m_pend[c]; m_t0[c] = cyc; m_st[c] = 1;
                    end
`ifdef GENERIC_CLKDIV_SYNC_EN
                    if (sync_in) begin
                        if (m_st[c] == 2) m_div[c] = m_pend[c];
                        m_t0[c] = cyc;
                    end
`endif
                    if (was_run && cfg_valid && rdy && !bad && int'(cfg_ch) == c) begin
                        m_st[c] = 2; m_pend[c] = cfg_div;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [3:0] e_out, e_ce, e_lk;
        logic [2:0] e3_out, e3_ce, e3_lk;
        int ph;
        forever begin
            @(posedge clk);
            #1;
            model_step();
            e_out = '0; e_ce = '0; e_lk = '0;
            for (int c = 0; c < NCH; c++) begin
                if (m_st[c] != 0) begin
                    ph       = (cyc - m_t0[c]) % m_div[c];
                    e_out[c] = (ph < (m_div[c] + 1) / 2);
                    e_ce[c]  = (ph == m_div[c] - 1);
                    e_lk[c]  = (m_st[c] == 1);
                end
            end
            chk("clk_out", clk_out, e_out);
            chk("clk_ce", clk_ce, e_ce);
            chk("locked", locked, e_lk);
            chk("all_locked", all_locked, &e_lk);
            chk("cfg_ready", cfg_ready, &e_lk);
            chk("cfg_err", cfg_err, m_err);
            e3_lk  = (cyc >= LOCK) ? 3'b111 : 3'b000;
            e3_out = (cyc >= LOCK && cyc % 2 == 0) ? 3'b111 : 3'b000;
            e3_ce  = (cyc > LOCK && cyc % 2 == 1) ? 3'b111 : 3'b000;
            chk("dut3_clk_out", clk_out3, e3_out);
            chk("dut3_clk_ce", clk_ce3, e3_ce);
            chk("dut3_locked", locked3, e3_lk);
            chk("dut3_all_locked", all_locked3, e3_lk[0]);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", cfg_ready, 1);
    endtask

    // Returns at the negedge following the handshake edge.
    task automatic send_cfg(input logic [1:0] ch, input logic [7:0] dv);
        @(negedge clk);
        wait_ready();
        cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] pat_o, pat_c;
        int n;

        // Reset release and warm-up
        repeat (3) @(negedge clk);
        chk("rst_clk_out", clk_out, 0);
        chk("rst_ready", cfg_ready, 0);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("warm_locked7", locked, 4'h0);
        chk("warm_out7", clk_out, 4'h0);
        @(posedge clk);
        #1;
        chk("lock_out8", clk_out, 4'hf);
        chk("lock_locked8", locked, 4'hf);
        chk("lock_all8", all_locked, 1);
        chk("lock_ce8", clk_ce, 4'h0);
        @(posedge clk);
        #1;
        chk("run_out9", clk_out, 4'h0);
        chk("run_ce9", clk_ce, 4'hf);

        // ch1 -> D=5
        send_cfg(2'd1, 8'd5);
        chk("reload_lk1", locked[1], 0);
        chk("reload_ready", cfg_ready, 0);
        chk("reload_lk0", locked[0], 1);
        n = 0;
        while (locked[1] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("reload_done", locked[1], 1);
        for (int i = 0; i < 5; i++) begin
            pat_o[4-i] = clk_out[1];
            pat_c[4-i] = clk_ce[1];
            @(negedge clk);
        end
        chk("d5_out_pattern", pat_o, 5'b11100);
        chk("d5_ce_pattern", pat_c, 5'b00001);

        // Rejected requests
        send_cfg(2'd2, 8'd1);
        chk("err_div1", cfg_err, 1);
        chk("err_div1_lk", locked, 4'hf);
        @(negedge clk);
        chk("err_div1_clr", cfg_err, 0);
        send_cfg(2'd3, 8'd0);
        chk("err_div0", cfg_err, 1);
        @(negedge clk);
        chk("err_div0_clr", cfg_err, 0);
        chk("dut3_ready", cfg_ready3, 1);
        cfg_valid3 = 1'b1; cfg_ch3 = 2'd3; cfg_div3 = 8'd5;
        @(negedge clk);
        cfg_valid3 = 1'b0;
        chk("err_ch3", cfg_err3, 1);
        @(negedge clk);
        chk("err_ch3_clr", cfg_err3, 0);

        // Handshake coincident with ch0 terminal count (D=2 -> 4)
        wait_ready();
        n = 0;
        while (clk_ce[0] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
        chk("ce0_wait", clk_ce[0], 1);
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
        @(posedge clk);
        #1;
        chk("tc_acc_lk", locked[0], 0);
        chk("tc_acc_out", clk_out[0], 1);
        @(negedge clk);
        cfg_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("tc_old_ce", clk_ce[0], 1);
        chk("tc_old_lk", locked[0], 0);
        @(posedge clk);
        #1;
        chk("tc_new_lk", locked[0], 1);
        chk("tc_new_out", clk_out[0], 1);
        repeat (3) @(posedge clk);
        #1;
        chk("tc_new_ce", clk_ce[0], 1);

        // Sync realignment: ch0 D=3, ch1 D=4
        send_cfg(2'd0, 8'd3);
        send_cfg(2'd1, 8'd4);
        @(negedge clk);
        wait_ready();
        repeat (2) @(negedge clk);
        sync_in = 1'b1;
        @(posedge clk);
        #1;
`ifdef GENERIC_CLKDIV_SYNC_EN
        chk("sync_out", clk_out[1:0], 2'b11);
`endif
        chk("sync_lk", locked[1:0], 2'b11);
        @(negedge clk);
        sync_in = 1'b0;
        repeat (12) @(negedge clk);

        // Reset mid-RELOAD
        send_cfg(2'd2, 8'd7);
        chk("mid_reload", locked[2], 0);
        rst = 1'b1;
        #1;
        chk("rstm_out", clk_out, 0);
        chk("rstm_ce", clk_ce, 0);
        chk("rstm_lk", locked, 0);
        chk("rstm_all", all_locked, 0);
        chk("rstm_ready", cfg_ready, 0);
        chk("rstm_err", cfg_err, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("rel_lk7", locked, 4'h0);
        @(posedge clk);
        #1;
        chk("rel_out8", clk_out, 4'hf);
        chk("rel_lk8", locked, 4'hf);
        @(posedge clk);
        #1;
        chk("rel_ce9", clk_ce, 4'hf);
        chk("rel_out9", clk_out, 4'h0);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
